// File: rtl/datapath_sequencer.sv
// Moore sequencer for the 8x16 register-file datapath: one command per start pulse.
// Define SEQ_FAST_DONE_EN to drop the DONE state and raise done in the WRITE cycle.
module datapath_sequencer #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [DW-1:0] imm,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          asel,
    output logic          vsel,
    output logic [1:0]    alu_op,
    output logic [DW-1:0] datapath_in,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOVR = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b11;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
`ifndef SEQ_FAST_DONE_EN
        , S_DONE = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [RW-1:0] rn_q, rn_d;
    logic [RW-1:0] rm_q, rm_d;
    logic [DW-1:0] imm_q, imm_d;

    // State and command-field registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            imm_q   <= imm_d;
        end
    end

    // Next-state, field capture and Moore output decode
    always_comb begin
        state_d  = S_IDLE;
        op_d     = op_q;
        rd_d     = rd_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        imm_d    = imm_q;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        alu_op   = ALU_ADD;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    rd_d  = rd;
                    rn_d  = rn;
                    rm_d  = rm;
                    imm_d = imm;
                    case (op)
                        OP_MOVI: state_d = S_WRITE;
                        OP_MOVR: state_d = S_LOAD_B;
                        default: state_d = S_LOAD_A;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: begin
                readnum = rn_q;
                loada   = 1'b1;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // MOVR goes through the adder as 0 + Rm
                loadc   = 1'b1;
                asel    = (op_q == OP_MOVR);
                alu_op  = (op_q == OP_AND) ? ALU_AND : ALU_ADD;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                writenum = rd_q;
                write    = 1'b1;
                vsel     = (op_q == OP_MOVI);
`ifdef SEQ_FAST_DONE_EN
                done     = 1'b1;
                state_d  = S_IDLE;
`else
                state_d  = S_DONE;
`endif
            end
`ifndef SEQ_FAST_DONE_EN
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign datapath_in = imm_q;
    assign busy        = (state_q != S_IDLE);

endmodule
